spi_regbank: RTL and testbench

//  SPI-slave register bank for tile configuration and monitoring: NUM_CFG read/write config registers plus NUM_STS

---
 rtl/spi_regbank_pkg.sv | 7 +
 rtl/spi_regbank_if.sv | 10 +
 rtl/spi_slave_if.sv | 138 +++++++++++++
 rtl/spi_regbank.sv | 89 ++++++++
 tb/tb_spi_regbank.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/spi_regbank_pkg.sv
// Shared types and constants for the SPI register bank.
// The command byte carries the write flag in its MSB and a 7-bit address in its low bits.
package spi_regbank_pkg;
    typedef enum logic [1:0] {IDLE, CMD, DATA} spi_state_e;
    localparam int CMD_W  = 8;
    localparam int RW_BIT = 7;
endpackage

// File: rtl/spi_regbank_if.sv
// SPI pin bundle between an external SPI master and the register bank.
interface spi_regbank_if;
    logic spi_cs_n;
    logic spi_clk;
    logic spi_mosi;
    logic spi_miso;

    modport master (output spi_cs_n, output spi_clk, output spi_mosi, input spi_miso);
    modport slave  (input spi_cs_n, input spi_clk, input spi_mosi, output spi_miso);
endinterface

// File: rtl/spi_slave_if.sv
// SPI mode-0 slave engine: pin sync, edge detect, frame FSM, shift registers and counters.
// Produces a registered write strobe per completed word and preloads read data for the next word.
module spi_slave_if
    import spi_regbank_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              ena,
    spi_regbank_if.slave      spi,
    output logic [ADDR_W-1:0] addr,
    output logic [WIDTH-1:0]  wdata,
    output logic              wr_stb,
    input  logic [WIDTH-1:0]  rdata
);
    localparam int SH_W  = (CMD_W > WIDTH) ? CMD_W : WIDTH;
    localparam int CNT_W = $clog2(SH_W);
    localparam logic [RW_BIT-1:0] LOW_MASK = RW_BIT'((1 << ADDR_W) - 1);

    logic [1:0]        cs_sync, sck_sync, mosi_sync;
    logic              cs_prev, sck_prev;
    logic              cs_s, sck_s, mosi_s;
    logic              cs_fall, sck_rise, sck_fall, frame_live;
    logic              cmd_done, word_done;
    spi_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [SH_W-1:0]   rx_q, shift_nxt;
    logic [WIDTH-1:0]  tx_q;
    logic              miso_q, rw_q, load_pend, inc_pend;
    logic [RW_BIT-1:0] addr_q;
    logic              in_range;

    // cs sync resets low so a frame already in progress at reset release is not seen as a new fall
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            cs_sync   <= '0;
            sck_sync  <= '0;
            mosi_sync <= '0;
            cs_prev   <= 1'b0;
            sck_prev  <= 1'b0;
        end else begin
            cs_sync   <= {cs_sync[0], spi.spi_cs_n};
            sck_sync  <= {sck_sync[0], spi.spi_clk};
            mosi_sync <= {mosi_sync[0], spi.spi_mosi};
            cs_prev   <= cs_sync[1];
            sck_prev  <= sck_sync[1];
        end
    end

    assign cs_s      = cs_sync[1];
    assign sck_s     = sck_sync[1];
    assign mosi_s    = mosi_sync[1];
    assign cs_fall   = cs_prev & ~cs_s;
    assign sck_rise  = sck_s & ~sck_prev;
    assign sck_fall  = ~sck_s & sck_prev;
    assign shift_nxt = {rx_q[SH_W-2:0], mosi_s};
    assign in_range  = (addr_q & ~LOW_MASK) == '0;
    assign addr      = addr_q[ADDR_W-1:0];

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        frame_live = ena & ~cs_s;
        cmd_done   = 1'b0;
        word_done  = 1'b0;
        case (state_q)
            IDLE: if (ena && cs_fall) state_d = CMD;
            CMD: begin
                if (frame_live && sck_rise && cnt_q == CNT_W'(CMD_W - 1)) begin
                    cmd_done = 1'b1;
                    state_d  = DATA;
                end
            end
            DATA: if (frame_live && sck_rise && cnt_q == CNT_W'(WIDTH - 1)) word_done = 1'b1;
            default: state_d = IDLE;
        endcase
        if (!frame_live) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            cnt_q     <= '0;
            rx_q      <= '0;
            tx_q      <= '0;
            miso_q    <= 1'b0;
            rw_q      <= 1'b0;
            addr_q    <= '0;
            wdata     <= '0;
            wr_stb    <= 1'b0;
            load_pend <= 1'b0;
            inc_pend  <= 1'b0;
        end else begin
            wr_stb    <= 1'b0;
            load_pend <= 1'b0;
            inc_pend  <= 1'b0;
            if (state_q == IDLE || state_d == IDLE) begin
                cnt_q  <= '0;
                miso_q <= 1'b0;
            end else begin
                if (sck_rise) begin
                    rx_q <= shift_nxt;
                    if (cmd_done) begin
                        cnt_q     <= '0;
                        rw_q      <= shift_nxt[RW_BIT];
                        addr_q    <= shift_nxt[RW_BIT-1:0];
                        load_pend <= 1'b1;
                    end else if (word_done) begin
                        cnt_q    <= '0;
                        wdata    <= shift_nxt[WIDTH-1:0];
                        wr_stb   <= rw_q & in_range;
                        inc_pend <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                // increment waits one clk so the write strobe still sees the word's own address
                if (inc_pend) begin
                    addr_q    <= (addr_q & ~LOW_MASK) | ((addr_q + RW_BIT'(1)) & LOW_MASK);
                    load_pend <= 1'b1;
                end
                if (load_pend) begin
                    tx_q <= in_range ? rdata : '0;
                end else if (sck_fall && state_q == DATA) begin
                    miso_q <= tx_q[WIDTH-1];
                    tx_q   <= tx_q << 1;
                end
            end
        end
    end

    assign spi.spi_miso = miso_q & (state_q != IDLE) & ~spi.spi_cs_n;
endmodule

// File: rtl/spi_regbank.sv
// SPI-accessible register bank: RW config registers plus sticky (W1C) or live status registers.
// Burst access auto-increments the address; config writes pulse cfg_wr_o after the new value lands.
module spi_regbank
    import spi_regbank_pkg::*;
#(
    parameter int                       NUM_CFG    = 8,
    parameter int                       NUM_STS    = 2,
    parameter int                       WIDTH      = 8,
    parameter int                       STS_STICKY = 1,
    parameter logic [NUM_CFG*WIDTH-1:0] CFG_RST    = '0
) (
    input  logic                     clk,
    input  logic                     rstb,
    input  logic                     ena,
    spi_regbank_if.slave             spi,
    output logic [NUM_CFG*WIDTH-1:0] cfg_o,
    output logic [NUM_CFG-1:0]       cfg_wr_o,
    input  logic [NUM_STS*WIDTH-1:0] sts_i
);
    localparam int ADDR_W = $clog2(NUM_CFG + NUM_STS);

    if (ADDR_W > RW_BIT) begin : g_addr_w_chk
        $error("spi_regbank: register map does not fit the 7-bit command address");
    end

    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  wdata, rdata;
    logic              wr_stb, wr_en;
    logic [WIDTH-1:0]  cfg_q   [NUM_CFG];
    logic [WIDTH-1:0]  sts_q   [NUM_STS];
    logic [WIDTH-1:0]  sts_clr [NUM_STS];

    spi_slave_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) u_spi (
        .clk    (clk),
        .rstb   (rstb),
        .ena    (ena),
        .spi    (spi),
        .addr   (addr),
        .wdata  (wdata),
        .wr_stb (wr_stb),
        .rdata  (rdata)
    );

    assign wr_en = wr_stb & ena;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            for (int k = 0; k < NUM_CFG; k++) cfg_q[k] <= CFG_RST[k*WIDTH +: WIDTH];
            cfg_wr_o <= '0;
        end else begin
            cfg_wr_o <= '0;
            for (int k = 0; k < NUM_CFG; k++) begin
                if (wr_en && addr == ADDR_W'(k)) begin
                    cfg_q[k]    <= wdata;
                    cfg_wr_o[k] <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int j = 0; j < NUM_STS; j++) begin
            sts_clr[j] = '0;
            if (wr_en && addr == ADDR_W'(NUM_CFG + j)) sts_clr[j] = wdata;
        end
    end

    // a set arriving in the same clk as its W1C wins because the OR is applied after the clear
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            for (int j = 0; j < NUM_STS; j++) sts_q[j] <= '0;
        end else begin
            for (int j = 0; j < NUM_STS; j++) begin
                if (STS_STICKY != 0) sts_q[j] <= (sts_q[j] & ~sts_clr[j]) | sts_i[j*WIDTH +: WIDTH];
                else                 sts_q[j] <= sts_i[j*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        rdata = '0;
        for (int k = 0; k < NUM_CFG; k++) if (addr == ADDR_W'(k)) rdata = cfg_q[k];
        for (int j = 0; j < NUM_STS; j++) if (addr == ADDR_W'(NUM_CFG + j)) rdata = sts_q[j];
    end

    for (genvar k = 0; k < NUM_CFG; k++) begin : g_cfg_o
        assign cfg_o[k*WIDTH +: WIDTH] = cfg_q[k];
    end
endmodule

// File: tb/tb_spi_regbank.sv
// Randomized bench for spi_regbank driving SPI frames and checking against an array-based register model.
module tb_spi_regbank;
    localparam logic [63:0] CFG_RST = 64'h0807060504030201;
    localparam time         HALF    = 60;

    logic        clk = 1'b0;
    logic        rstb = 1'b0;
    logic        ena = 1'b0;
    logic [63:0] cfg_o;
    logic [7:0]  cfg_wr_o;
    logic [15:0] sts_i = '0;

    spi_regbank_if spi();

    spi_regbank #(
        .NUM_CFG(8), .NUM_STS(2), .WIDTH(8), .STS_STICKY(1), .CFG_RST(CFG_RST)
    ) dut (
        .clk(clk), .rstb(rstb), .ena(ena), .spi(spi),
        .cfg_o(cfg_o), .cfg_wr_o(cfg_wr_o), .sts_i(sts_i)
    );

    always #5 clk = ~clk;

    logic [7:0] cfg_m [8];
    logic [7:0] sts_m [2];
    logic [7:0] sts_hold [2];
    int         exp_pulse [8];
    int         seen_pulse [8];
    logic [7:0] tx_buf [4];
    logic [7:0] rx_buf [4];
    logic [7:0] exp_rd [4];
    logic       miso_or;
    int         n_tests = 0;
    int         n_fail = 0;
    int         rw, a, nw, ex;

    always @(negedge clk) begin
        for (int k = 0; k < 8; k++) if (cfg_wr_o[k]) seen_pulse[k]++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] model_read(input int adr);
        if (adr < 8)  return cfg_m[adr];
        if (adr < 10) return sts_m[adr-8];
        return 8'h00;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 8; k++) cfg_m[k] = CFG_RST[k*8 +: 8];
        for (int j = 0; j < 2; j++) sts_m[j] = 8'h00;
    endtask

    task automatic model_frame(input logic [7:0] cmd, input int nwords);
        int adr = int'(cmd[6:0]);
        for (int i = 0; i < nwords; i++) begin
            exp_rd[i] = model_read(adr);
            if (cmd[7]) begin
                if (adr < 8) begin
                    cfg_m[adr] = tx_buf[i];
                    exp_pulse[adr]++;
                end else if (adr < 10) begin
                    sts_m[adr-8] = (sts_m[adr-8] & ~tx_buf[i]) | sts_hold[adr-8];
                end
            end
            adr = (adr + 1) % 16;
        end
    endtask

    task automatic spi_bit(input logic v, output logic m);
        spi.spi_mosi = v;
        #HALF;
        m = spi.spi_miso;
        spi.spi_clk = 1'b1;
        #HALF;
        spi.spi_clk = 1'b0;
    endtask

    task automatic spi_frame(input logic [7:0] cmd, input int nwords, input int extra);
        logic m;
        miso_or = 1'b0;
        spi.spi_cs_n = 1'b0;
        #HALF;
        for (int b = 7; b >= 0; b--) begin
            spi_bit(cmd[b], m);
            miso_or |= m;
        end
        for (int w = 0; w < nwords; w++) begin
            for (int b = 7; b >= 0; b--) begin
                spi_bit(tx_buf[w][b], m);
                rx_buf[w][b] = m;
                miso_or |= m;
            end
        end
        for (int b = 0; b < extra; b++) begin
            spi_bit(1'($urandom), m);
            miso_or |= m;
        end
        #HALF;
        spi.spi_cs_n = 1'b1;
        spi.spi_mosi = 1'b0;
        #(4*HALF);
    endtask

    task automatic check_regs();
        logic [63:0] exp_cfg;
        for (int k = 0; k < 8; k++) exp_cfg[k*8 +: 8] = cfg_m[k];
        check("cfg_o", cfg_o, exp_cfg);
        for (int k = 0; k < 8; k++) check("wr_pulse_count", 64'(seen_pulse[k]), 64'(exp_pulse[k]));
    endtask

    task automatic run_frame(input logic [7:0] cmd, input int nwords, input int extra);
        spi_frame(cmd, nwords, extra);
        model_frame(cmd, nwords);
        for (int i = 0; i < nwords; i++) check("read_word", 64'(rx_buf[i]), 64'(exp_rd[i]));
        check_regs();
    endtask

    task automatic pulse_sts(input int j, input logic [7:0] v);
        @(negedge clk);
        sts_i[j*8 +: 8] = v | sts_hold[j];
        @(negedge clk);
        sts_i[j*8 +: 8] = sts_hold[j];
        sts_m[j] |= v;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        spi.spi_cs_n = 1'b1;
        spi.spi_clk  = 1'b0;
        spi.spi_mosi = 1'b0;
        sts_hold[0]  = 8'h00;
        sts_hold[1]  = 8'h00;
        model_reset();
        repeat (5) @(posedge clk);
        #1;
        check("reset_cfg_o", cfg_o, CFG_RST);
        check("reset_cfg_wr_o", 64'(cfg_wr_o), 64'h0);
        check("reset_miso", 64'(spi.spi_miso), 64'h0);
        @(negedge clk);
        rstb = 1'b1;
        ena  = 1'b1;
        repeat (5) @(negedge clk);

        tx_buf[0] = 8'h00;
        run_frame(8'h03, 1, 0);
        check("read_addr3", 64'(rx_buf[0]), 64'h04);

        tx_buf[0] = 8'hA5;
        run_frame(8'h83, 1, 0);

        tx_buf[0] = 8'h11; tx_buf[1] = 8'h22; tx_buf[2] = 8'h33;
        run_frame(8'h86, 3, 0);

        pulse_sts(0, 8'h04);
        run_frame(8'h08, 1, 0);
        check("sticky_set", 64'(rx_buf[0]), 64'h04);
        tx_buf[0] = 8'h04;
        run_frame(8'h88, 1, 0);
        run_frame(8'h08, 1, 0);
        check("sticky_cleared", 64'(rx_buf[0]), 64'h00);
        sts_hold[0] = 8'h04;
        @(negedge clk);
        sts_i[7:0] = sts_hold[0];
        sts_m[0] |= sts_hold[0];
        tx_buf[0] = 8'h04;
        run_frame(8'h88, 1, 0);
        run_frame(8'h08, 1, 0);
        check("sticky_set_wins", 64'(rx_buf[0]), 64'h04);
        sts_hold[0] = 8'h00;
        @(negedge clk);
        sts_i[7:0] = 8'h00;
        run_frame(8'h08, 1, 0);
        tx_buf[0] = 8'hFF;
        run_frame(8'h88, 1, 0);

        tx_buf[0] = 8'($urandom);
        run_frame(8'h81, 0, 5);
        tx_buf[0] = 8'($urandom);
        run_frame(8'h81, 1, 0);

        ena = 1'b0;
        tx_buf[0] = 8'($urandom);
        spi_frame(8'h85, 1, 0);
        check("ena_low_miso", 64'(miso_or), 64'h0);
        check_regs();
        ena = 1'b1;
        repeat (4) @(negedge clk);

        for (int it = 0; it < 24; it++) begin
            if ($urandom_range(0, 2) == 0) pulse_sts(int'($urandom_range(0, 1)), 8'($urandom));
            rw = int'($urandom_range(0, 1));
            a  = int'($urandom_range(0, 15));
            nw = int'($urandom_range(1, 3));
            ex = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 7)) : 0;
            for (int w = 0; w < 4; w++) tx_buf[w] = 8'($urandom);
            run_frame({1'(rw), 3'b000, 4'(a)}, nw, ex);
        end

        for (int w = 0; w < 3; w++) tx_buf[w] = 8'($urandom);
        fork
            spi_frame(8'h80, 3, 0);
            begin
                #2460;
                rstb = 1'b0;
                #25;
                rstb = 1'b1;
            end
        join
        cfg_m[0] = tx_buf[0];
        exp_pulse[0]++;
        model_reset();
        check_regs();
        check("rst_mid_burst_cfg", cfg_o, CFG_RST);
        for (int w = 0; w < 3; w++) tx_buf[w] = 8'h00;
        run_frame(8'h80, 3, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
